// File: rtl/riscv_boot_loader.sv
// Byte-stream boot loader: parses a length-prefixed little-endian image and writes it into instruction memory.
// Write strobe the cycle after a word's 4th byte (one bubble per word); stalls on in_valid=0; holds core in reset until done.
module riscv_boot_loader #(
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [15:0] n;
  logic [15:0] idx;
  logic [1:0]  bidx;
  logic [31:0] wbuf;
  logic        accept;
  logic [15:0] n_full;
  logic [15:0] idx_inc;

  assign accept  = in_valid & in_ready;
  assign n_full  = {in_byte, n[7:0]};
  assign idx_inc = idx + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) state <= LEN0;
    else      state <= state_nxt;
  end

  // Accepting states always have in_ready=1, so in_valid alone qualifies a transfer here.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = 32'h0;
    imem_wdata = 32'h0;
    core_rst   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      LEN0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LEN1;
      end
      LEN1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_full == 16'd0)                state_nxt = DONE;
          else if ({1'b0, n_full} > MAX_N)    state_nxt = ERR;
          else                                state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && bidx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = BASE_ADDR + {14'd0, idx, 2'b00};
        imem_wdata = wbuf;
        state_nxt  = (idx_inc == n) ? DONE : DATA;
      end
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_nxt = LEN0;
    endcase
  end

  // The byte index wraps to 0 after lane 3, so it is already cleared when DATA resumes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n    <= 16'd0;
      idx  <= 16'd0;
      bidx <= 2'd0;
      wbuf <= 32'h0;
    end else begin
      case (state)
        LEN0: if (accept) n[7:0] <= in_byte;
        LEN1: begin
          if (accept) begin
            n[15:8] <= in_byte;
            idx     <= 16'd0;
            bidx    <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            wbuf[{bidx, 3'b000} +: 8] <= in_byte;
            bidx                      <= bidx + 2'd1;
          end
        end
        WRITE: idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Scoreboard bench for riscv_boot_loader: a byte-position model predicts handshake/status and queues expected writes,
// a negedge monitor pops and compares every imem write (address, data, cycle).
module tb_riscv_boot_loader;

  localparam int          MAXW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         expq[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];

  // Reference model in terms of stream byte positions
  int          m_pos;
  int          m_n;
  int          m_words;
  bit          m_bubble;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_wbuf;

  riscv_boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (imem_we !== 1'b0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got we=%b addr=%0h data=%0h expected no write (cycle %0d)",
                 imem_we, imem_addr, imem_wdata, cyc);
      end else begin
        e = expq.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic model_clear();
    m_pos = 0; m_n = 0; m_words = 0;
    m_bubble = 0; m_done = 0; m_err = 0; m_wbuf = 32'h0;
  endtask

  task automatic model_accept(input logic [7:0] b, input int t);
    int  dp;
    wr_t w;
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n + (int'(b) << 8);
      if (m_n == 0)         m_done = 1;
      else if (m_n > MAXW)  m_err  = 1;
    end else begin
      dp = m_pos - 2;
      m_wbuf[8*(dp%4) +: 8] = b;
      if (dp % 4 == 3) begin
        w.addr = BASE + 32'(4 * m_words);
        w.data = m_wbuf;
        w.cyc  = t + 1;
        expq.push_back(w);
        m_words++;
        m_bubble = 1;
      end
    end
    m_pos++;
  endtask

  // Entered and left at a negedge: check status, drive, let one rising edge happen.
  task automatic step(input bit v, input logic [7:0] b, output bit acc);
    bit exp_rdy;
    int t;
    exp_rdy = !m_done && !m_err && !m_bubble;
    chk("in_ready", in_ready, exp_rdy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("core_rst", core_rst, !m_done);
    in_valid = v;
    in_byte  = b;
    t        = cyc;
    acc      = v && exp_rdy;
    @(posedge clk);
    if (m_bubble) begin
      m_bubble = 0;
      if (m_words == m_n) m_done = 1;
    end else if (acc) begin
      model_accept(b, t);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k, input bit v);
    bit acc;
    for (int i = 0; i < k; i++) step(v, 8'($urandom), acc);
  endtask

  // mode 0: valid held high, 1: toggling, 2: random
  task automatic run_stream(input int mode, input int stop_at);
    int         p;
    int         budget;
    bit         acc;
    bit         v;
    bit         tog;
    logic [7:0] b;
    p = 0; tog = 1;
    budget = 4 * stream.size() + 40;
    while ((p < stop_at || m_bubble) && !m_done && !m_err) begin
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: got %0d bytes accepted expected %0d", p, stop_at);
        break;
      end
      budget--;
      case (mode)
        0:       v = 1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      b = (p < stream.size()) ? stream[p] : 8'($urandom);
      step(v, b, acc);
      if (acc) p++;
    end
  endtask

  task automatic build(input int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) stream.push_back(words[i][8*k +: 8]);
    end
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Reset with a byte offered on the same edge; that byte must be discarded.
  task automatic do_reset();
    chk("pending_writes", expq.size(), 0);
    expq.delete();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; in_byte = 8'h0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Three-word program, back-to-back bytes
    words = '{32'h0010_0293, 32'h0040_0313, 32'h0062_83B3};
    build(3);
    run_stream(0, stream.size());
    idle(3, 0);

    // Empty image
    do_reset();
    words.delete();
    build(0);
    run_stream(0, stream.size());
    idle(3, 1);

    // Oversized header, trailing bytes must be ignored
    do_reset();
    words.delete();
    build(MAXW + 1);
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    run_stream(0, stream.size());
    idle(10, 1);

    // Single word with in_valid toggling
    do_reset();
    words = '{32'hDEAD_BEEF};
    build(1);
    run_stream(1, stream.size());
    idle(4, 0);

    // Reset in the middle of word 1, then a fresh one-word image
    do_reset();
    rand_words(2);
    build(2);
    run_stream(0, 8);
    do_reset();
    words = '{32'h0000_0013};
    build(1);
    run_stream(0, stream.size());
    idle(10, 1);

    // Largest accepted image
    do_reset();
    rand_words(MAXW);
    build(MAXW);
    run_stream(2, stream.size());
    idle(3, 1);

    // Random images, including occasional oversized headers
    for (int r = 0; r < 10; r++) begin
      do_reset();
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(MAXW + 1, 16'hFFFF) : $urandom_range(0, 9);
      rand_words((n > MAXW) ? 2 : n);
      build(n);
      run_stream(2, stream.size());
      idle(4, $urandom_range(0, 1) == 1);
    end

    chk("pending_writes", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_boot_loader.md
RISCV_BOOT_LOADER -- requirements
Module: riscv_boot_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first written word.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset (rst=0 at a rising edge resets).
REQ-005 in_valid  input  1  SHALL mean a byte is offered on in_byte.
REQ-006 in_byte  input  8  SHALL carry the offered byte.
REQ-007 in_ready  output  1  SHALL mean the loader accepts in_byte this cycle.
REQ-008 imem_we  output  1  SHALL mean a write strobe to instruction memory.
REQ-009 imem_addr  output  32  SHALL carry the byte address of the word being written.
REQ-010 imem_wdata  output  32  SHALL carry the instruction word being written.
REQ-011 core_rst  output  1  SHALL be the active-high reset held on the downstream riscv core.
REQ-012 done  output  1  SHALL mean the image is fully loaded.
REQ-013 err  output  1  SHALL mean the image header was rejected.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; in_byte is ignored otherwise.
REQ-015 Stream format SHALL be: 2-byte word count N (little-endian), then 4*N image bytes, each word little-endian (first byte -> bits 7:0).
REQ-016 States SHALL be LEN0, LEN1, DATA, WRITE, DONE, ERR; all outputs decode from registered state (Moore).
REQ-017 LEN0: in_ready=1; on accept, latch N[7:0] -> LEN1.
REQ-018 LEN1: in_ready=1; on accept, latch N[15:8]; if N=0 -> DONE; if N>MAX_WORDS -> ERR; else -> DATA with word index 0 and byte index 0.
REQ-019 DATA: in_ready=1; each accept stores the byte at lane byte index and increments the 2-bit byte index; the accept at byte index 3 -> WRITE.
REQ-020 WRITE: in_ready=0, imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*index (32-bit, wrap modulo 2^32), imem_wdata=assembled word.
REQ-021 WRITE exit: increment index; if new index equals N -> DONE, else -> DATA with byte index 0.
REQ-022 Latency: imem_we SHALL assert in the cycle immediately after the 4th byte of a word is accepted; done in the cycle after the last WRITE.
REQ-023 Throughput: one byte per cycle in DATA, exactly one bubble cycle (WRITE) per word.
REQ-024 DONE: in_ready=0, done=1, core_rst=0, imem_we=0; state held until reset; further in_valid ignored.
REQ-025 ERR: in_ready=0, err=1, core_rst=1, no writes; held until reset.
REQ-026 In LEN0, LEN1, DATA, WRITE: core_rst=1, done=0, err=0.
REQ-027 imem_addr and imem_wdata SHALL be don't-care when imem_we=0 but SHALL NOT change during the WRITE cycle.
REQ-028 in_valid dropping mid-word SHALL stall without losing stored bytes or index.

Reset
REQ-029 rst=0 at any rising edge, including mid-word or during WRITE, SHALL force LEN0, clear N, index, byte index and word buffer.
REQ-030 Outputs in the cycle after reset: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0.
REQ-031 rst has priority over any simultaneous byte accept; that byte SHALL be discarded.

Verification
REQ-032 Load N=3 with words 0x00100293, 0x00400313, 0x006283B3, in_valid held 1 -> writes at addresses 0x0, 0x4, 0x8 with those data, one per 5 cycles; done=1 and core_rst=0 one cycle after the third write; core then yields x7=5.
REQ-033 N=0 (bytes 0x00,0x00) -> no imem_we; done=1, core_rst=0 in the cycle after the second byte.
REQ-034 N=MAX_WORDS+1 (65 -> bytes 0x41,0x00) -> err=1, in_ready=0, core_rst=1, zero writes; subsequent bytes ignored.
REQ-035 N=1, in_valid toggled 1/0 every cycle for word 0xDEADBEEF -> single write, data 0xDEADBEEF at BASE_ADDR, no extra writes.
REQ-036 N=2, assert rst=0 after the 2nd byte of word 1, then resend N=1 with 0x00000013 -> only one write after reset, address 0x0, data 0x00000013, done=1.
REQ-037 After done=1, drive in_valid=1 for 10 cycles -> in_ready stays 0, imem_we stays 0, done stays 1.
